// File: rtl/fp16_intn_mul_pipe.sv
// LANES-wide FP16 x INT_W multiplier: 3 stages (decode, multiply, output) producing {sign, unbiased exp, integer product}.
// Optional FP16_INTN_MUL_SPECIAL_EN adds out_special with per-lane {nan, inf} flags.
module fp16_intn_mul_pipe #(
   parameter int INT_W    = 8,
   parameter int LANES    = 4,
   parameter int EXP_BIAS = 15
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        in_signed,
   input  logic [16*LANES-1:0]         in_act,
   input  logic [INT_W*LANES-1:0]      in_wgt,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES-1:0]            out_sign,
   output logic [6*LANES-1:0]          out_exp,
   output logic [(INT_W+11)*LANES-1:0] out_man,
   output logic [LANES-1:0]            out_zero
`ifdef FP16_INTN_MUL_SPECIAL_EN
   ,
   output logic [2*LANES-1:0]          out_special
`endif
);

   localparam int MAN_W = INT_W + 11;

   // Handshake: a transfer happens on a cycle where valid & ready are both high; the whole pipe
   // freezes only when the output holds a result nobody takes, so in_ready never depends on in_valid.
   logic stall;
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   logic             d_sign_a [LANES];
   logic             d_sign_w [LANES];
   logic [5:0]       d_exp    [LANES];
   logic [10:0]      d_man_a  [LANES];
   logic [INT_W-1:0] d_mag    [LANES];

   logic             s1_valid;
   logic             s1_sign_a [LANES];
   logic             s1_sign_w [LANES];
   logic [5:0]       s1_exp    [LANES];
   logic [10:0]      s1_man_a  [LANES];
   logic [INT_W-1:0] s1_mag    [LANES];

   logic [MAN_W-1:0] p_man [LANES];

   logic             s2_valid;
   logic             s2_sign [LANES];
   logic [5:0]       s2_exp  [LANES];
   logic [MAN_W-1:0] s2_man  [LANES];
   logic             s2_zero [LANES];

`ifdef FP16_INTN_MUL_SPECIAL_EN
   logic [1:0] d_special  [LANES];
   logic [1:0] s1_special [LANES];
   logic [1:0] s2_special [LANES];
`endif

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [15:0]      act;
      logic [INT_W-1:0] wgt;
      logic [4:0]       e;
      logic [9:0]       m;
      logic             neg;

      assign act = in_act[16*i +: 16];
      assign wgt = in_wgt[INT_W*i +: INT_W];
      assign e   = act[14:10];
      assign m   = act[9:0];
      assign neg = in_signed & wgt[INT_W-1];

      assign d_sign_a[i] = act[15];
      assign d_sign_w[i] = neg;
      assign d_man_a[i]  = {e != 5'd0, m};
      // Subnormals share the smallest normal exponent; the hidden bit is simply absent.
      assign d_exp[i]    = (e == 5'd0) ? 6'(1 - EXP_BIAS) : {1'b0, e} - 6'(EXP_BIAS);
      // Two's-complement negate as unsigned: the most negative weight maps to 2^(INT_W-1) cleanly.
      assign d_mag[i]    = neg ? (~wgt) + INT_W'(1) : wgt;

`ifdef FP16_INTN_MUL_SPECIAL_EN
      // {nan, inf}: inf times a zero weight is nan.
      assign d_special[i] = {(e == 5'h1f) & ((m != 10'd0) | (d_mag[i] == '0)),
                             (e == 5'h1f) & (m == 10'd0) & (d_mag[i] != '0)};
`endif

      assign p_man[i] = MAN_W'(s1_mag[i]) * MAN_W'(s1_man_a[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         out_sign  <= '0;
         out_exp   <= '0;
         out_man   <= '0;
         out_zero  <= '0;
         for (int i = 0; i < LANES; i++) begin
            s1_sign_a[i] <= 1'b0;
            s1_sign_w[i] <= 1'b0;
            s1_exp[i]    <= '0;
            s1_man_a[i]  <= '0;
            s1_mag[i]    <= '0;
            s2_sign[i]   <= 1'b0;
            s2_exp[i]    <= '0;
            s2_man[i]    <= '0;
            s2_zero[i]   <= 1'b0;
         end
      end else if (!stall) begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         for (int i = 0; i < LANES; i++) begin
            s1_sign_a[i] <= d_sign_a[i];
            s1_sign_w[i] <= d_sign_w[i];
            s1_exp[i]    <= d_exp[i];
            s1_man_a[i]  <= d_man_a[i];
            s1_mag[i]    <= d_mag[i];

            s2_sign[i]   <= s1_sign_a[i] ^ s1_sign_w[i];
            s2_exp[i]    <= s1_exp[i];
            s2_man[i]    <= p_man[i];
            s2_zero[i]   <= (p_man[i] == '0);

            // A zero product is reported as +0 with a clean exponent.
            out_sign[i]              <= s2_sign[i] & ~s2_zero[i];
            out_exp[6*i +: 6]        <= s2_zero[i] ? 6'd0 : s2_exp[i];
            out_man[MAN_W*i +: MAN_W] <= s2_man[i];
            out_zero[i]              <= s2_zero[i];
         end
      end
   end

`ifdef FP16_INTN_MUL_SPECIAL_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         out_special <= '0;
         for (int i = 0; i < LANES; i++) begin
            s1_special[i] <= 2'b00;
            s2_special[i] <= 2'b00;
         end
      end else if (!stall) begin
         for (int i = 0; i < LANES; i++) begin
            s1_special[i]         <= d_special[i];
            s2_special[i]         <= s1_special[i];
            out_special[2*i +: 2] <= s2_special[i];
         end
      end
   end
`endif

endmodule
